// File: rtl/imem_fetch_ctrl_if.sv
// rtl/imem_fetch_ctrl_if.sv - ROM, decode and redirect signals of the instruction-fetch sequencer
interface imem_fetch_ctrl_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_stall;

  modport master (
    output mem_addr,
    output instr_valid,
    output instr,
    output instr_pc,
    output fetch_stall,
    input  mem_rdata,
    input  instr_ready,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  mem_addr,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    input  fetch_stall,
    output mem_rdata,
    output instr_ready,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - fetch PC sequencer with ROM wait states, prefetch queue and redirect flush
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned DEPTH    = 2
) (
  input logic               clk,
  input logic               reset,
  imem_fetch_ctrl_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [3:0]       LAST_C  = 4'(MEM_WAIT - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_CAPTURE,
    S_HOLD
  } state_t;

  // With a single wait state every edge is a capture edge, so WAIT is never visited.
  localparam state_t START_S = state_t'((MEM_WAIT == 1) ? S_CAPTURE : S_WAIT);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] data_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic at_capture;
  logic pop;
  logic can_push;
  logic push;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;

    at_capture = (state_q != S_WAIT);
    pop        = (count_q != '0) && bus.instr_ready;
    can_push   = (count_q < DEPTH_C) || pop;
    push       = at_capture && can_push && !bus.redirect_valid;

    if (bus.redirect_valid) begin
      state_d = START_S;
      cnt_d   = '0;
      pc_d    = bus.redirect_pc & 32'hFFFF_FFFC;
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          cnt_d   = cnt_q + 4'd1;
          state_d = ((cnt_q + 4'd1) == LAST_C) ? S_CAPTURE : S_WAIT;
        end
        S_CAPTURE, S_HOLD: begin
          // Holding keeps mem_addr and the counter frozen so rdata stays valid.
          if (can_push) begin
            cnt_d   = '0;
            pc_d    = pc_q + 32'd4;
            state_d = START_S;
          end else begin
            state_d = S_HOLD;
          end
        end
        default: state_d = START_S;
      endcase

      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;

      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= START_S;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (push) begin
      data_mem[wr_q] <= bus.mem_rdata;
      pc_mem[wr_q]   <= pc_q;
    end
  end

  assign bus.mem_addr    = pc_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr       = data_mem[rd_q];
  assign bus.instr_pc    = pc_mem[rd_q];
  assign bus.fetch_stall = at_capture && !can_push;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        rdy;
  logic        rv;
  logic [31:0] rpc;

  int n_chk  = 0;
  int n_fail = 0;

  imem_fetch_ctrl_if bus0 ();
  imem_fetch_ctrl_if bus1 ();

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h2009_0006;
      default:       return 32'hC0DE_0000 ^ a;
    endcase
  endfunction

  assign bus0.mem_rdata      = rom(bus0.mem_addr);
  assign bus0.instr_ready    = rdy;
  assign bus0.redirect_valid = rv;
  assign bus0.redirect_pc    = rpc;
  assign bus1.mem_rdata      = rom(bus1.mem_addr);
  assign bus1.instr_ready    = rdy;
  assign bus1.redirect_valid = rv;
  assign bus1.redirect_pc    = rpc;

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .MEM_WAIT(2), .DEPTH(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  imem_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .MEM_WAIT(3), .DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mw(input int k);
    return (k == 0) ? 2 : 3;
  endfunction
  function automatic int dp(input int k);
    return (k == 0) ? 2 : 4;
  endfunction
  function automatic logic [31:0] rst_pc(input int k);
    return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
  endfunction

  // Reference: a FIFO of {word, pc} filled once MEM_WAIT edges have elapsed on an address.
  int          m_cnt   [2];
  int          m_el    [2];
  bit          m_fresh [2];
  logic [31:0] m_fpc   [2];
  logic [31:0] m_qi    [2][4];
  logic [31:0] m_qp    [2][4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_cnt[k]   = 0;
    m_el[k]    = 0;
    m_fresh[k] = 1'b1;
    m_fpc[k]   = rst_pc(k);
  endtask

  task automatic model_edge(input int k);
    bit deq, cap;
    if (rv) begin
      m_cnt[k] = 0;
      m_el[k]  = 0;
      m_fpc[k] = {rpc[31:2], 2'b00};
    end else begin
      deq = (m_cnt[k] > 0) && rdy;
      cap = (m_el[k] == mw(k) - 1) && ((m_cnt[k] - int'(deq)) < dp(k));
      if (deq) begin
        for (int i = 0; i < 3; i++) begin
          m_qi[k][i] = m_qi[k][i+1];
          m_qp[k][i] = m_qp[k][i+1];
        end
        m_cnt[k]--;
      end
      if (cap) begin
        m_qi[k][m_cnt[k]] = rom(m_fpc[k]);
        m_qp[k][m_cnt[k]] = m_fpc[k];
        m_cnt[k]++;
        m_fpc[k]   = m_fpc[k] + 32'd4;
        m_el[k]    = 0;
        m_fresh[k] = 1'b0;
      end else if (m_el[k] < mw(k) - 1) begin
        m_el[k]++;
      end
    end
  endtask

  task automatic check_model(input int k);
    logic        v, st;
    logic [31:0] ins, pc, addr;
    bit          e_st;
    if (k == 0) begin
      v = bus0.instr_valid; st = bus0.fetch_stall; ins = bus0.instr; pc = bus0.instr_pc; addr = bus0.mem_addr;
    end else begin
      v = bus1.instr_valid; st = bus1.fetch_stall; ins = bus1.instr; pc = bus1.instr_pc; addr = bus1.mem_addr;
    end
    e_st = (m_el[k] == mw(k) - 1) && (m_cnt[k] == dp(k)) && !rdy;
    chk($sformatf("model_valid dut%0d", k), 32'(v), 32'(m_cnt[k] > 0));
    chk($sformatf("model_addr dut%0d", k), addr, m_fpc[k]);
    chk($sformatf("model_stall dut%0d", k), 32'(st), 32'(e_st));
    if (m_cnt[k] > 0) begin
      chk($sformatf("model_instr dut%0d", k), ins, m_qi[k][0]);
      chk($sformatf("model_pc dut%0d", k), pc, m_qp[k][0]);
    end else if (m_fresh[k]) begin
      chk($sformatf("model_instr0 dut%0d", k), ins, 32'h0);
      chk($sformatf("model_pc0 dut%0d", k), pc, 32'h0);
    end
  endtask

  task automatic apply(input bit r, input bit rd, input bit rvv, input logic [31:0] rp);
    reset = r;
    rdy   = rd;
    rv    = rvv;
    rpc   = rp;
    if (r) begin
      model_reset(0);
      model_reset(1);
    end
    #1;
    check_model(0);
    check_model(1);
  endtask

  task automatic advance();
    @(posedge clk);
    if (!reset) begin
      model_edge(0);
      model_edge(1);
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          head;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic        e_stall;
  } vec_t;

  vec_t        tbl [22];
  logic [31:0] got [3];
  int          n_got;

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0, 32'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0, 32'h00, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0, 32'h00, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h2008_0005, 32'h0, 32'h04, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 32'h04, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h2009_0006, 32'h4, 32'h08, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0, 32'h00, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h00, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h00, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h2008_0005, 32'h0, 32'h04, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h2008_0005, 32'h0, 32'h04, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h2008_0005, 32'h0, 32'h08, 1'b0};
    for (int i = 12; i < 17; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h2008_0005, 32'h0, 32'h08, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h2008_0005, 32'h0, 32'h08, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h2009_0006, 32'h4, 32'h0C, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hC0DE_0008, 32'h8, 32'h0C, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hC0DE_000C, 32'hC, 32'h10, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 32'h10, 1'b0};

    reset = 1'b1; rdy = 1'b0; rv = 1'b0; rpc = '0;
    model_reset(0);
    model_reset(1);
    @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].rst, tbl[i].rdy, 1'b0, 32'h0);
      chk($sformatf("tbl%0d valid", i), 32'(bus0.instr_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d addr", i), bus0.mem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d stall", i), 32'(bus0.fetch_stall), 32'(tbl[i].e_stall));
      if (tbl[i].head) begin
        chk($sformatf("tbl%0d instr", i), bus0.instr, tbl[i].e_instr);
        chk($sformatf("tbl%0d pc", i), bus0.instr_pc, tbl[i].e_pc);
      end
      advance();
    end

    // Redirect to an unaligned target while pc 4 sits in the queue.
    apply(1'b1, 1'b1, 1'b0, 32'h0); advance();
    for (int i = 0; i < 4; i++) begin apply(1'b0, 1'b1, 1'b0, 32'h0); advance(); end
    apply(1'b0, 1'b1, 1'b1, 32'h0000_001A);
    chk("t3 pre pc", bus0.instr_pc, 32'h4);
    advance();
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t3 flush valid", 32'(bus0.instr_valid), 32'h0);
    chk("t3 target addr", bus0.mem_addr, 32'h18);
    advance();
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t3 wait valid", 32'(bus0.instr_valid), 32'h0);
    advance();
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t3 target valid", 32'(bus0.instr_valid), 32'h1);
    chk("t3 target pc", bus0.instr_pc, 32'h18);
    chk("t3 target instr", bus0.instr, 32'hC0DE_0018);
    advance();

    // Redirect coinciding with a capture of pc 4 and a dequeue of pc 0.
    apply(1'b1, 1'b0, 1'b0, 32'h0); advance();
    for (int i = 0; i < 3; i++) begin apply(1'b0, 1'b0, 1'b0, 32'h0); advance(); end
    apply(1'b0, 1'b1, 1'b1, 32'h0000_0040);
    chk("t4 pre pc", bus0.instr_pc, 32'h0);
    chk("t4 pre addr", bus0.mem_addr, 32'h4);
    advance();
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 1'b1, 1'b0, 32'h0);
      chk("t4 flush valid", 32'(bus0.instr_valid), 32'h0);
      advance();
    end
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t4 next pc", bus0.instr_pc, 32'h40);
    advance();

    // Address wrap past 32'hFFFF_FFFC on the second instance.
    apply(1'b1, 1'b1, 1'b0, 32'h0); advance();
    n_got = 0;
    for (int i = 0; i < 40 && n_got < 3; i++) begin
      apply(1'b0, 1'b1, 1'b0, 32'h0);
      if (bus1.instr_valid) begin
        got[n_got] = bus1.instr_pc;
        n_got++;
      end
      advance();
    end
    chk("t5 delivered count", 32'(n_got), 32'd3);
    if (n_got == 3) begin
      chk("t5 pc0", got[0], 32'hFFFF_FFF8);
      chk("t5 pc1", got[1], 32'hFFFF_FFFC);
      chk("t5 pc2", got[2], 32'h0000_0000);
    end

    // Asynchronous reset in WAIT with a full queue.
    apply(1'b1, 1'b0, 1'b0, 32'h0); advance();
    for (int i = 0; i < 4; i++) begin apply(1'b0, 1'b0, 1'b0, 32'h0); advance(); end
    apply(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t6 full valid", 32'(bus0.instr_valid), 32'h1);
    chk("t6 full addr", bus0.mem_addr, 32'h8);
    #2;
    reset = 1'b1;
    model_reset(0);
    model_reset(1);
    #1;
    chk("t6 rst valid", 32'(bus0.instr_valid), 32'h0);
    chk("t6 rst instr", bus0.instr, 32'h0);
    chk("t6 rst pc", bus0.instr_pc, 32'h0);
    chk("t6 rst addr", bus0.mem_addr, 32'h0);
    chk("t6 rst stall", 32'(bus0.fetch_stall), 32'h0);
    chk("t6 rst addr1", bus1.mem_addr, 32'hFFFF_FFF8);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin apply(1'b0, 1'b1, 1'b0, 32'h0); advance(); end
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t6 restart pc", bus0.instr_pc, 32'h0);
    chk("t6 restart instr", bus0.instr, 32'h2008_0005);
    advance();

    // Random traffic against the reference for both parameter sets.
    for (int i = 0; i < 800; i++) begin
      apply($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 65,
            $urandom_range(0, 99) < 7, $urandom);
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer between the program counter and the instruction ROM.
- Owns the fetch PC and drives byte addresses to the ROM.
- Waits a fixed number of cycles to cover the ROM's combinational propagation delay, then captures the word into a small prefetch queue.
- Presents queued instructions to decode with a valid/ready handshake.
- Accepts branch/jump redirects that flush all speculative fetches.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset; low 2 bits must be 0.
MEM_WAIT, 2, clock edges from mem_addr change to rdata capture; legal range 1..15.
DEPTH, 2, prefetch queue entries; legal values 2 or 4.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
mem_addr  out  32  byte address to the instruction ROM; registered.
mem_rdata  in  32  instruction word from the ROM.
instr_valid  out  1  queue head is valid.
instr  out  32  queue head instruction word.
instr_pc  out  32  byte address of the queue head.
instr_ready  in  1  decode accepts the head this cycle.
redirect_valid  in  1  branch/jump taken; one-cycle pulse.
redirect_pc  in  32  redirect target.
fetch_stall  out  1  queue full and no capture possible this cycle.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: fetch PC = RESET_PC, mem_addr = RESET_PC, wait counter = 0, queue empty, instr_valid = 0, instr = 0, instr_pc = 0, fetch_stall = 0.
- Reset may assert mid-fetch. It immediately clears all state; no partially waited fetch survives.
- mem_addr always equals the current fetch PC, driven from a register.
- States:
  - WAIT: wait counter increments each edge.
  - CAPTURE: the edge where counter == MEM_WAIT-1.
  - HOLD: queue full.
- Capture at the CAPTURE edge, allowed if count < DEPTH, or if the head dequeues on the same edge:
  - push {mem_rdata, fetch PC} into the queue;
  - fetch PC += 4, 32-bit wrap (32'hFFFF_FFFC -> 0);
  - counter -> 0.
- If capture is not allowed, enter HOLD:
  - counter stays at MEM_WAIT-1 and fetch_stall = 1;
  - mem_addr stays constant, so rdata remains stable;
  - capture happens on the first edge with space.
- Throughput: one instruction per MEM_WAIT cycles when not stalled.
- First-instruction latency: instr_valid rises after the MEM_WAIT-th rising edge following reset deassertion.
- Dequeue: the head retires on an edge where instr_valid && instr_ready.
  - instr and instr_pc are driven combinationally from the queue head.
  - instr_valid = (count != 0).
- Enqueue and dequeue on the same edge: both occur and count is unchanged. This works at full and at count == 1.
- Redirect (redirect_valid = 1 at the edge) has priority over everything:
  - queue flushed, count = 0;
  - any capture and any dequeue on that edge are discarded;
  - fetch PC = {redirect_pc[31:2], 2'b00}, counter = 0.
  - Next captured word is the target, MEM_WAIT edges later; instr_valid = 0 meanwhile.
- Back-to-back redirects: the last one wins; each restarts the wait.
- Redirect while in HOLD: leaves HOLD, fetch_stall -> 0 next cycle.
- Queue: circular, rd/wr pointers wrap modulo DEPTH, count width clog2(DEPTH)+1.
  - No overflow possible: capture is gated.
  - No underflow possible: dequeue requires instr_valid.
- Invariant: instr_pc values presented to decode are consecutive (+4) except immediately after a redirect.

Test Plan:
1. Reset only; ROM holds 0x20080005 @0, 0x20090006 @4. Release reset, instr_ready = 1 -> instr_valid rises after 2nd edge with instr = 0x20080005, instr_pc = 0. Next valid 2 cycles later: 0x20090006, pc = 4.
2. instr_ready = 0 for 10 cycles -> queue fills with pc 0 and pc 4; fetch_stall = 1 and mem_addr = 8 held. Raise ready -> pc 0, 4, 8 delivered in order, none lost or duplicated.
3. Redirect to 0x0000_001A while the queue holds pc 4 -> queue flushed, instr_valid = 0 for MEM_WAIT cycles, then instr_pc = 0x18 with ROM word 0x18.
4. Redirect on the same edge as a capture and a dequeue -> the captured word never appears; the next delivered pc is the redirect target.
5. RESET_PC = 32'hFFFF_FFF8, ready = 1 -> pcs delivered are FFFF_FFF8, FFFF_FFFC, 0000_0000.
6. Assert reset mid-WAIT with a full queue -> all outputs at reset values in the same cycle; the sequence restarts from RESET_PC.
